// File: rtl/comp_divider.sv
// Sequential 32-bit unsigned restoring divider, one quotient bit per clock.
// Shares the run/ready handshake of the shift-add multiplier.
module comp_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Dividend,
    input  logic [31:0] Divisor,
    input  logic        run,
    output logic [31:0] Quotient,
    output logic [31:0] Remainder,
    output logic        ready,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t      state;
    logic [5:0]  count;
    logic [31:0] divisor;
    logic [63:0] work;

    // One restoring step. The shifted partial remainder keeps its carry-out
    // (33 bits) so divisors at or above 2^31 still compare correctly.
    function automatic logic [63:0] restore_step(input logic [63:0] w,
                                                 input logic [31:0] d);
        logic        [32:0] shifted;
        logic signed [33:0] diff;
        shifted = w[63:31];
        diff    = $signed({1'b0, shifted}) - $signed({2'b00, d});
        if (diff >= 34'sd0)
            return {diff[31:0], w[30:0], 1'b1};
        else
            return {shifted[31:0], w[30:0], 1'b0};
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            count       <= 6'd0;
            divisor     <= 32'd0;
            work        <= 64'd0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (run) begin
                        divisor <= Divisor;
                        count   <= 6'd0;
                        if (Divisor == 32'd0) begin
                            work        <= {Dividend, 32'hFFFF_FFFF};
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end else begin
                            work        <= {32'd0, Dividend};
                            div_by_zero <= 1'b0;
                            state       <= CALC;
                        end
                    end
                end
                CALC: begin
                    work  <= restore_step(work, divisor);
                    count <= count + 6'd1;
                    if (count == 6'd31)
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Quotient  = work[31:0];
    assign Remainder = work[63:32];
    assign ready     = (state == DONE);

endmodule

// File: tb/tb_comp_divider.sv
// Randomized self-checking bench for comp_divider against an arithmetic reference.
module tb_comp_divider;

    logic        clk;
    logic        reset;
    logic [31:0] Dividend;
    logic [31:0] Divisor;
    logic        run;
    logic [31:0] Quotient;
    logic [31:0] Remainder;
    logic        ready;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    comp_divider dut (
        .clk        (clk),
        .reset      (reset),
        .Dividend   (Dividend),
        .Divisor    (Divisor),
        .run        (run),
        .Quotient   (Quotient),
        .Remainder  (Remainder),
        .ready      (ready),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_quot(input logic [31:0] dd, input logic [31:0] dv);
        return (dv == 32'd0) ? 32'hFFFF_FFFF : dd / dv;
    endfunction

    function automatic logic [31:0] ref_rem(input logic [31:0] dd, input logic [31:0] dv);
        return (dv == 32'd0) ? dd : dd % dv;
    endfunction

    function automatic logic [31:0] rand_divisor();
        case ($urandom_range(0, 4))
            0:       return 32'd0;
            1:       return 32'h8000_0000 | 32'($urandom);
            2:       return 32'($urandom_range(1, 255));
            default: return 32'($urandom) >> $urandom_range(0, 31);
        endcase
    endfunction

    // Single pulsed operation: checks ready timing, result and flag.
    task automatic do_op(input string tag, input logic [31:0] dd, input logic [31:0] dv);
        int lat;
        lat = (dv == 32'd0) ? 1 : 32;
        @(negedge clk);
        Dividend = dd;
        Divisor  = dv;
        run      = 1'b1;
        @(posedge clk);
        #1;
        run      = 1'b0;
        Dividend = 32'($urandom);
        Divisor  = 32'($urandom);
        for (int c = 1; c <= lat; c++) begin
            if (c == lat) begin
                check_eq({tag, "_ready_early"}, 32'(ready), (lat == 1) ? 32'd1 : 32'd0);
            end
            @(posedge clk);
            #1;
        end
        check_eq({tag, "_ready"}, 32'(ready), 32'd1);
        check_eq({tag, "_quot"}, Quotient, ref_quot(dd, dv));
        check_eq({tag, "_rem"}, Remainder, ref_rem(dd, dv));
        check_eq({tag, "_dbz"}, 32'(div_by_zero), (dv == 32'd0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got no finish, expected finish before 500000 ns");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] dd;
        logic [31:0] dv;
        int          lat;
        int          rdy_seen;

        reset    = 1'b0;
        run      = 1'b0;
        Dividend = 32'd0;
        Divisor  = 32'd0;
        #12;
        check_eq("rst_quot", Quotient, 32'd0);
        check_eq("rst_rem", Remainder, 32'd0);
        check_eq("rst_ready", 32'(ready), 32'd0);
        check_eq("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        do_op("basic", 32'd100, 32'd7);
        do_op("big_dvsr", 32'hFFFF_FFFF, 32'h8000_0000);
        do_op("dvsr_one", 32'hFFFF_FFFF, 32'd1);
        do_op("small", 32'd3, 32'd10);
        do_op("zero_dd", 32'd0, 32'd5);
        do_op("div0", 32'd1234, 32'd0);
        do_op("after_div0", 32'd77, 32'd9);
        for (int i = 0; i < 6; i++)
            do_op("rand", 32'($urandom), rand_divisor());

        // run held high: each new op is accepted on the first edge with ready=1
        @(negedge clk);
        dd = 32'($urandom);
        dv = rand_divisor();
        Dividend = dd;
        Divisor  = dv;
        run      = 1'b1;
        for (int op = 0; op < 10; op++) begin
            lat = (dv == 32'd0) ? 1 : 32;
            @(posedge clk);
            for (int c = 1; c <= lat; c++) begin
                @(posedge clk);
                #1;
                if (c == lat) begin
                    check_eq("hs_ready", 32'(ready), 32'd1);
                    check_eq("hs_quot", Quotient, ref_quot(dd, dv));
                    check_eq("hs_rem", Remainder, ref_rem(dd, dv));
                    check_eq("hs_dbz", 32'(div_by_zero), (dv == 32'd0) ? 32'd1 : 32'd0);
                end else if (c == lat - 1) begin
                    check_eq("hs_ready_early", 32'(ready), 32'd0);
                end
                @(negedge clk);
                if (c == lat) begin
                    dd = 32'($urandom);
                    dv = rand_divisor();
                    Dividend = dd;
                    Divisor  = dv;
                end else begin
                    Dividend = 32'($urandom);
                    Divisor  = 32'($urandom);
                end
            end
        end
        @(posedge clk);
        #1;
        run = 1'b0;
        check_eq("hs_restart_ready", 32'(ready), (dv == 32'd0) ? 32'd1 : 32'd0);

        // reset dropped in the middle of a calculation
        @(negedge clk);
        Dividend = 32'd100;
        Divisor  = 32'd7;
        run      = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_eq("midrst_quot", Quotient, 32'd0);
        check_eq("midrst_rem", Remainder, 32'd0);
        check_eq("midrst_ready", 32'(ready), 32'd0);
        check_eq("midrst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        rdy_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready) rdy_seen++;
        end
        check_eq("idle_no_ready", 32'(rdy_seen), 32'd0);
        do_op("post_rst", 32'd50, 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/comp_divider.md
# comp_divider

Sequential 32-bit unsigned divider: the inverse companion to the team's shift-add multiplier, sharing its run/ready handshake style. It uses restoring division, one quotient bit per clock, through a single 64-bit remainder/quotient register and a 33-bit subtractor. It sits beside the multiplier in the PA1 datapath and is driven by the same testbench-level controller.

## Interface

- No parameters; widths fixed at 32-bit operands, 32-bit results.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately when low.
- Dividend  input  32  unsigned dividend, sampled on the accepting edge only.
- Divisor  input  32  unsigned divisor, sampled on the accepting edge only.
- run  input  1  start request, level-sampled at rising edge.
- Quotient  output  32  unsigned quotient, lower half of the working register.
- Remainder  output  32  unsigned remainder, upper half of the working register.
- ready  output  1  result valid; high only in DONE.
- div_by_zero  output  1  high with ready when the accepted Divisor was 0.

## Operation

- States: IDLE, CALC, DONE. Reset forces IDLE.
- Accept: run=1 at a rising edge while in IDLE or DONE.
  - Latch Divisor into an internal 32-bit register.
  - Load the working register W[63:0] = {32'h0, Dividend}.
  - Clear the 6-bit iteration counter, clear div_by_zero, go to CALC.
- Divisor==0 at accept:
  - Load W = {Dividend, 32'hFFFFFFFF}, set div_by_zero=1, go directly to DONE.
  - Result: Quotient=FFFFFFFF, Remainder=Dividend.
- CALC iteration, one per cycle:
  - S = {W[63:0],1'b0}[64:32] (33 bits: shifted upper half including carry-out).
  - D = S − {1'b0,divisor} (34-bit signed compare).
  - If D ≥ 0: W = {D[31:0], W[30:0], 1'b1}.
  - Else: W = {S[31:0], W[30:0], 1'b0}.
  - Counter increments; after the 32nd iteration (counter==31), go to DONE.
- DONE: W is held; ready=1. A new run restarts as described under Accept. With run=0, DONE persists indefinitely.
- run while in CALC: ignored; does not restart or extend the operation. Input changes during CALC have no effect.
- Arithmetic invariant at DONE with divisor≠0: Dividend = Quotient·Divisor + Remainder, and Remainder < Divisor.
- The 33-bit shifted partial remainder is mandatory. Dividing by divisors ≥ 2^31 must not lose the shifted-out MSB.

## Timing

- Reset values: Quotient=0, Remainder=0, ready=0, div_by_zero=0, state IDLE, counter=0, latched divisor=0.
- Reset asserted mid-CALC: outputs clear immediately (asynchronously). After deassertion, the block waits in IDLE for run.
- Latency, divisor≠0: run accepted at edge N → ready=1 after edge N+32, i.e. 32 CALC cycles.
- Latency, divisor=0: ready=1 after edge N+1.
- ready drops on the edge that accepts a new run. Back-to-back operations are therefore separated by exactly 33 cycles of ready=0 … 1 pattern: 32 cycles low, then high.
- Quotient and Remainder show intermediate values during CALC. They are valid only while ready=1.
- No combinational path from inputs to outputs. All outputs are registered or decoded from registered state.

## Test plan

- Basic: Dividend=100, Divisor=7, run pulsed one cycle → ready high exactly 32 cycles after the accept edge; Quotient=14, Remainder=2, div_by_zero=0.
- Large divisor: Dividend=FFFFFFFF, Divisor=80000000 → Quotient=1, Remainder=7FFFFFFF. Dividend=FFFFFFFF, Divisor=1 → Quotient=FFFFFFFF, Remainder=0.
- Small dividend: Dividend=3, Divisor=10 → Quotient=0, Remainder=3. Dividend=0, Divisor=5 → Quotient=0, Remainder=0.
- Divide by zero: Dividend=1234, Divisor=0 → ready and div_by_zero high 1 cycle after accept; Quotient=FFFFFFFF, Remainder=1234. The next normal division clears div_by_zero.
- Handshake: run held high continuously with changing operands.
  - run during CALC is ignored; each result matches the operands sampled at its accept edge.
  - A new operation starts on the first edge where ready=1.
- Reset mid-op: drop reset at CALC cycle 10 → outputs read 0 asynchronously. After release, with no run, ready stays 0. A fresh run of 50/6 → Quotient=8, Remainder=2.
